// File: rtl/rop3_pkg.sv
// ----------------------------------------------------------------------------
// rop3_pkg
// Shared definitions for the ROP3 streaming front end.
//   rop3_state_e : job controller states (IDLE, RUN, DRAIN)
//   ROP_*        : common ternary raster-op mode codes. Each code is the truth
//                  table of the op, indexed by {P,S,D} per bit position.
// ----------------------------------------------------------------------------
package rop3_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rop3_state_e;

   localparam logic [7:0] ROP_BLACKNESS = 8'h00;
   localparam logic [7:0] ROP_DSTINVERT = 8'h55;
   localparam logic [7:0] ROP_SRCCOPY   = 8'hCC;
   localparam logic [7:0] ROP_PATCOPY   = 8'hF0;
   localparam logic [7:0] ROP_SRCINVERT = 8'h66;
   localparam logic [7:0] ROP_WHITENESS = 8'hFF;

endpackage

// File: rtl/rop3_res_fifo.sv
// ----------------------------------------------------------------------------
// rop3_res_fifo
// Small synchronous FIFO that buffers ROP3 results (data plus a last-beat
// sideband bit) until the result consumer is ready.
// Parameters:
//   WIDTH : entry width
//   DEPTH : number of entries
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle (caller guarantees room)
//   push_data   : entry to write
//   pop         : remove the head entry (ignored when empty)
//   pop_data    : current head entry, stable until popped
//   full, empty : occupancy flags
// Pointers are an index that wraps modulo DEPTH plus a wrap-phase bit, so
// DEPTH does not have to be a power of two. Push and pop in the same cycle
// both take effect at any occupancy, including full.
// ----------------------------------------------------------------------------
module rop3_res_fifo
   import rop3_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_idx_q;
   logic [AW-1:0]    rd_idx_q;
   logic             wr_wrap_q;
   logic             rd_wrap_q;
   logic             do_pop;

   // Same index with the same phase means nothing stored; same index with
   // opposite phase means the writer has lapped the reader.
   assign empty    = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
   assign full     = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_idx_q];

   // Storage array carries no reset; contents only become visible once the
   // write pointer has moved past them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx_q] <= push_data;
      end
   end

   // Write pointer advance, flipping the phase bit when the index wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_q  <= '0;
         wr_wrap_q <= 1'b0;
      end else if (push) begin
         if (wr_idx_q == LAST_IDX) begin
            wr_idx_q  <= '0;
            wr_wrap_q <= ~wr_wrap_q;
         end else begin
            wr_idx_q <= wr_idx_q + 1'b1;
         end
      end
   end

   // Read pointer advance, mirroring the write side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_idx_q  <= '0;
         rd_wrap_q <= 1'b0;
      end else if (do_pop) begin
         if (rd_idx_q == LAST_IDX) begin
            rd_idx_q  <= '0;
            rd_wrap_q <= ~rd_wrap_q;
         end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rop3_stream_ctrl.sv
// ----------------------------------------------------------------------------
// rop3_stream_ctrl
// Job-level streaming front end for the registered ROP3 raster-op stage.
// Accepts one job descriptor (mode, beat count), feeds operand beats into the
// ROP3 stage, tracks its fixed latency with a token line and returns results
// on a valid/ready stream with full backpressure.
// Parameters:
//   N          : operand / result width
//   LEN_W      : job beat count width
//   ROP_LAT    : cycles from rop_p/s/d changing to rop_result valid
//   FIFO_DEPTH : result buffer entries (must be >= ROP_LAT)
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   cmd_valid/ready/mode/len : job descriptor handshake (ready only in IDLE)
//   op_valid/ready, op_p/s/d : operand beat stream
//   rop_p/s/d, rop_mode      : operands and mode driven to the ROP3 stage
//   rop_result               : ROP3 stage output
//   res_valid/ready/data/last: result stream, last marks the final beat
//   done                     : one-cycle pulse at job completion
// Optional build macro ROP3_STREAM_PERF_EN adds perf_busy_cyc and
// perf_stall_cyc saturating counters, cleared on every accepted job.
// ----------------------------------------------------------------------------
module rop3_stream_ctrl
   import rop3_pkg::*;
#(
   parameter int N          = 4,
   parameter int LEN_W      = 16,
   parameter int ROP_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_mode,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [N-1:0]     op_p,
   input  logic [N-1:0]     op_s,
   input  logic [N-1:0]     op_d,
   output logic [N-1:0]     rop_p,
   output logic [N-1:0]     rop_s,
   output logic [N-1:0]     rop_d,
   output logic [7:0]       rop_mode,
   input  logic [N-1:0]     rop_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N-1:0]     res_data,
   output logic             res_last,
`ifdef ROP3_STREAM_PERF_EN
   output logic [31:0]      perf_busy_cyc,
   output logic [31:0]      perf_stall_cyc,
`endif
   output logic             done
);

   localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);
   localparam logic [LEN_W-1:0]  ONE_BEAT = LEN_W'(1);

   if (FIFO_DEPTH < ROP_LAT) begin : g_depth_check
      $error("rop3_stream_ctrl: FIFO_DEPTH must be >= ROP_LAT");
   end

   rop3_state_e       state_q;
   rop3_state_e       state_d;
   logic [7:0]        mode_q;
   logic [LEN_W-1:0]  remaining_q;
   logic [CRED_W-1:0] credits_q;
   logic [ROP_LAT:0]  tok_vld_q;
   logic [ROP_LAT:0]  tok_last_q;
   logic              zero_done_q;

   logic              cmd_fire;
   logic              op_fire;
   logic              res_fire;
   logic              last_beat;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [N:0]        fifo_head;

   // Handshake decode. An operand beat needs both job beats left and a free
   // result slot reserved (a credit), which is what keeps the FIFO from ever
   // overflowing without stalling the ROP3 pipeline.
   assign cmd_ready = (state_q == IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign op_ready  = (state_q == RUN) && (remaining_q != '0) && (credits_q != '0);
   assign op_fire   = op_valid && op_ready;
   assign last_beat = (remaining_q == ONE_BEAT);
   assign res_valid = !fifo_empty;
   assign res_fire  = res_valid && res_ready;
   assign res_data  = res_valid ? fifo_head[N-1:0] : '0;
   assign res_last  = res_valid && fifo_head[N];
   assign rop_mode  = mode_q;
   assign done      = (res_fire && res_last) || zero_done_q;

   // The token leaving the end of the line lines up with rop_result being
   // valid for the beat that launched it. Credits mean there is always room,
   // but the full check keeps the FIFO write strictly legal.
   assign fifo_push = tok_vld_q[ROP_LAT] && (!fifo_full || res_fire);

   rop3_res_fifo #(
      .WIDTH (N + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({tok_last_q[ROP_LAT], rop_result}),
      .pop       (res_fire),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Job state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A zero-length job never leaves IDLE; DRAIN ends when
   // the beat flagged as last leaves the result buffer, which by construction
   // is also the moment the buffer and token line are empty.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_fire && (cmd_len != '0)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (op_fire && last_beat) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (res_fire && res_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Job bookkeeping: latched mode, beats left to accept, and the one-cycle
   // completion flag for zero-length jobs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= '0;
         remaining_q <= '0;
         zero_done_q <= 1'b0;
      end else begin
         zero_done_q <= cmd_fire && (cmd_len == '0);
         if (cmd_fire) begin
            mode_q      <= cmd_mode;
            remaining_q <= cmd_len;
         end else if (op_fire) begin
            remaining_q <= remaining_q - 1'b1;
         end
      end
   end

   // Credit counter: one credit per result slot, spent on operand accept and
   // returned on result pop; both in one cycle cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q <= CRED_MAX;
      end else begin
         unique case ({op_fire, res_fire})
            2'b10:   credits_q <= credits_q - 1'b1;
            2'b01:   credits_q <= credits_q + 1'b1;
            default: credits_q <= credits_q;
         endcase
      end
   end

   // Operand register feeding the ROP3 stage. It holds its value between
   // beats; the ROP3 stage recomputes the stale value harmlessly because no
   // token accompanies it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rop_p <= '0;
         rop_s <= '0;
         rop_d <= '0;
      end else if (op_fire) begin
         rop_p <= op_p;
         rop_s <= op_s;
         rop_d <= op_d;
      end
   end

   // Token line: stage 0 shadows the operand register, the following ROP_LAT
   // stages shadow the ROP3 pipeline. The last-beat flag travels alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_vld_q  <= '0;
         tok_last_q <= '0;
      end else begin
         tok_vld_q  <= {tok_vld_q[ROP_LAT-1:0], op_fire};
         tok_last_q <= {tok_last_q[ROP_LAT-1:0], op_fire && last_beat};
      end
   end

`ifdef ROP3_STREAM_PERF_EN
   // Performance counters: busy counts cycles outside IDLE, stall counts
   // cycles where a result waits on the consumer. Both stick at all-ones and
   // restart with each accepted job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cyc  <= '0;
         perf_stall_cyc <= '0;
      end else if (cmd_fire) begin
         perf_busy_cyc  <= '0;
         perf_stall_cyc <= '0;
      end else begin
         if ((state_q != IDLE) && (perf_busy_cyc != 32'hFFFF_FFFF)) begin
            perf_busy_cyc <= perf_busy_cyc + 32'd1;
         end
         if (res_valid && !res_ready && (perf_stall_cyc != 32'hFFFF_FFFF)) begin
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rop3_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rop3_stream_ctrl
// Testbench for rop3_stream_ctrl together with a behavioural two-register
// ROP3 stage. Expected results are held in a queue and compared in order as
// results handshake; table vectors, hand sequences and randomized jobs all
// feed that queue.
// ----------------------------------------------------------------------------
module tb_rop3_stream_ctrl;
   import rop3_pkg::*;

   localparam int N     = 4;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_mode;
   logic [LEN_W-1:0] cmd_len;
   logic             op_valid;
   logic             op_ready;
   logic [N-1:0]     op_p, op_s, op_d;
   logic [N-1:0]     rop_p, rop_s, rop_d;
   logic [7:0]       rop_mode;
   logic [N-1:0]     rop_result;
   logic             res_valid;
   logic             res_ready;
   logic [N-1:0]     res_data;
   logic             res_last;
   logic             done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0;
   int outstanding = 0;
   int first_acc_cyc = 0;
   int first_valid_cyc = -1;
   bit rr_random = 1'b0;

   logic [N-1:0] bp[$];
   logic [N-1:0] bs[$];
   logic [N-1:0] bd[$];
   logic [N:0]   exp_q[$];

   typedef struct {
      string        name;
      logic [7:0]   mode;
      logic [N-1:0] p;
      logic [N-1:0] s;
      logic [N-1:0] d;
      logic [N-1:0] exp;
   } vec_t;
   vec_t tbl[8];

   rop3_stream_ctrl #(
      .N          (N),
      .LEN_W      (LEN_W),
      .ROP_LAT    (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_len    (cmd_len),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_p       (op_p),
      .op_s       (op_s),
      .op_d       (op_d),
      .rop_p      (rop_p),
      .rop_s      (rop_s),
      .rop_d      (rop_d),
      .rop_mode   (rop_mode),
      .rop_result (rop_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_last   (res_last),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Reference raster op: each result bit is the mode bit selected by the
   // number 4*P + 2*S + D formed from that bit position's operands.
   function automatic logic [N-1:0] ropModel(input logic [7:0] mode, input logic [N-1:0] p,
                                             input logic [N-1:0] s, input logic [N-1:0] d);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         int k;
         k = 4 * p[i] + 2 * s[i] + d[i];
         r[i] = ((mode >> k) & 8'h01) != 8'h00;
      end
      return r;
   endfunction

   // Behavioural ROP3 stage: input register then output register.
   logic [N-1:0] st_p, st_s, st_d;
   logic [7:0]   st_mode;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_p <= '0; st_s <= '0; st_d <= '0; st_mode <= '0;
         rop_result <= '0;
      end else begin
         st_p <= rop_p; st_s <= rop_s; st_d <= rop_d; st_mode <= rop_mode;
         rop_result <= ropModel(st_mode, st_p, st_s, st_d);
      end
   end

   always @(posedge clk) cyc++;

   // Random consumer backpressure when enabled.
   always @(posedge clk) begin
      #1;
      if (rr_random) res_ready = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result monitor: in-order comparison against the expectation queue,
   // completion pulse counting and outstanding-beat bound.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [N:0] e;
         if (res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (op_valid && op_ready) outstanding++;
         if (res_valid && res_ready) begin
            outstanding--;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("res_data", res_data, e[N-1:0]);
               checkOutput("res_last", res_last, e[N]);
            end
            if (res_last) checkOutput("done_with_last", done, 1);
         end
         if ((op_valid && op_ready) || (res_valid && res_ready))
            checkOutput("credit_bound", (outstanding >= 0) && (outstanding <= 4), 1);
         if (done) done_cnt++;
      end
   end

   task automatic startJob(input logic [7:0] mode, input int len);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_len   = LEN_W'(len);
      @(negedge clk);
      checkOutput("cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pumpBeats(input int budget, input int upto, input bit gaps, inout int idx);
      int c;
      bit hs;
      c = 0;
      while (idx < upto && c < budget) begin
         op_p = bp[idx]; op_s = bs[idx]; op_d = bd[idx];
         op_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         hs = op_valid && op_ready;
         @(posedge clk); #1;
         if (hs) begin
            if (idx == 0) first_acc_cyc = cyc;
            idx++;
         end
         c++;
      end
      op_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int c;
      c = 0;
      do begin
         @(negedge clk); #1;
         c++;
      end while (!(exp_q.size() == 0 && cmd_ready) && c < budget);
      checkOutput("drain_timeout", (exp_q.size() == 0) && cmd_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic clearBeats();
      bp.delete(); bs.delete(); bd.delete();
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
      checkOutput({tag, "_op_ready"}, op_ready, 0);
      checkOutput({tag, "_res_valid"}, res_valid, 0);
      checkOutput({tag, "_res_data"}, res_data, 0);
      checkOutput({tag, "_res_last"}, res_last, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_rop_mode"}, rop_mode, 0);
      checkOutput({tag, "_rop_psd"}, {rop_p, rop_s, rop_d}, 0);
   endtask

   // One single-beat job from the vector table.
   task automatic applyStimulus(input vec_t v);
      int idx;
      int d0;
      clearBeats();
      bp.push_back(v.p); bs.push_back(v.s); bd.push_back(v.d);
      exp_q.push_back({1'b1, v.exp});
      d0 = done_cnt;
      startJob(v.mode, 1);
      idx = 0;
      pumpBeats(20, 1, 1'b0, idx);
      checkOutput({v.name, "_accept"}, idx, 1);
      waitIdle(50);
      checkOutput({v.name, "_done"}, done_cnt - d0, 1);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int idx;
      int d0;
      logic [3:0] sv[3];

      cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0;
      op_valid = 1'b0; op_p = '0; op_s = '0; op_d = '0;
      res_ready = 1'b1;

      tbl[0] = '{"srccopy",   8'hCC, 4'h0, 4'hA, 4'h3, 4'hA};
      tbl[1] = '{"srcinvert", 8'h66, 4'h0, 4'hC, 4'hA, 4'h6};
      tbl[2] = '{"dstinvert", 8'h55, 4'h7, 4'h2, 4'h3, 4'hC};
      tbl[3] = '{"patcopy",   8'hF0, 4'h9, 4'h4, 4'h6, 4'h9};
      tbl[4] = '{"blackness", 8'h00, 4'hF, 4'hF, 4'hF, 4'h0};
      tbl[5] = '{"whiteness", 8'hFF, 4'h0, 4'h0, 4'h0, 4'hF};
      tbl[6] = '{"and_sd",    8'h88, 4'h5, 4'hC, 4'hA, 4'h8};
      tbl[7] = '{"p_xor_d",   8'h5A, 4'h9, 4'h0, 4'h3, 4'hA};

      // Reset state
      #1 rst_n = 1'b0;
      #2 checkResetOutputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: SRCCOPY, three beats, latency and last flag
      $display("[TB] srccopy three-beat job");
      sv[0] = 4'hA; sv[1] = 4'h5; sv[2] = 4'hF;
      clearBeats();
      for (int i = 0; i < 3; i++) begin
         bp.push_back(4'($urandom)); bs.push_back(sv[i]); bd.push_back(4'($urandom));
         exp_q.push_back({(i == 2), sv[i]});
      end
      d0 = done_cnt;
      first_valid_cyc = -1;
      startJob(ROP_SRCCOPY, 3);
      idx = 0;
      pumpBeats(20, 3, 1'b0, idx);
      checkOutput("t1_accepts", idx, 3);
      waitIdle(50);
      checkOutput("t1_latency", first_valid_cyc - first_acc_cyc, 3);
      checkOutput("t1_done", done_cnt - d0, 1);

      // 2: table of single-beat jobs
      $display("[TB] single-beat vector table");
      for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

      // 3: backpressure fills the buffer, then release
      $display("[TB] backpressure job");
      clearBeats();
      for (int i = 0; i < 8; i++) begin
         bp.push_back(4'($urandom)); bs.push_back(4'(i + 1)); bd.push_back(4'($urandom));
         exp_q.push_back({(i == 7), 4'(i + 1)});
      end
      d0 = done_cnt;
      res_ready = 1'b0;
      startJob(ROP_SRCCOPY, 8);
      idx = 0;
      pumpBeats(20, 8, 1'b0, idx);
      checkOutput("t3_accepts_stalled", idx, 4);
      checkOutput("t3_op_ready_low", op_ready, 0);
      checkOutput("t3_res_valid", res_valid, 1);
      checkOutput("t3_buffered", outstanding, 4);
      res_ready = 1'b1;
      pumpBeats(100, 8, 1'b0, idx);
      checkOutput("t3_accepts_total", idx, 8);
      waitIdle(100);
      checkOutput("t3_remaining_exp", exp_q.size(), 0);
      checkOutput("t3_done", done_cnt - d0, 1);

      // 4: zero-length job
      $display("[TB] zero-length job");
      d0 = done_cnt;
      startJob(ROP_SRCCOPY, 0);
      @(negedge clk);
      checkOutput("t4_done_pulse", done, 1);
      checkOutput("t4_op_ready", op_ready, 0);
      checkOutput("t4_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      checkOutput("t4_done_cleared", done, 0);
      checkOutput("t4_done_count", done_cnt - d0, 1);
      @(posedge clk); #1;

      // 5: reset aborts a job after two of five beats
      $display("[TB] abort by reset");
      clearBeats();
      for (int i = 0; i < 5; i++) begin
         bp.push_back(4'($urandom)); bs.push_back(4'($urandom)); bd.push_back(4'($urandom));
         exp_q.push_back({(i == 4), bs[i]});
      end
      d0 = done_cnt;
      startJob(ROP_SRCCOPY, 5);
      idx = 0;
      pumpBeats(20, 2, 1'b0, idx);
      checkOutput("t5_accepts", idx, 2);
      rst_n = 1'b0;
      exp_q.delete();
      outstanding = 0;
      #2 checkResetOutputs("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t5_no_done", done_cnt - d0, 0);
      checkOutput("t5_res_valid_idle", res_valid, 0);
      clearBeats();
      for (int i = 0; i < 2; i++) begin
         bp.push_back(4'($urandom)); bs.push_back(4'($urandom)); bd.push_back(4'($urandom));
         exp_q.push_back({(i == 1), 4'hF});
      end
      startJob(ROP_WHITENESS, 2);
      idx = 0;
      pumpBeats(20, 2, 1'b0, idx);
      waitIdle(50);
      checkOutput("t5_done", done_cnt - d0, 1);

      // 6: DSTINVERT, 100 random beats, random consumer
      $display("[TB] dstinvert random job");
      clearBeats();
      for (int i = 0; i < 100; i++) begin
         bp.push_back(4'($urandom)); bs.push_back(4'($urandom)); bd.push_back(4'($urandom));
         exp_q.push_back({(i == 99), ~bd[i]});
      end
      d0 = done_cnt;
      rr_random = 1'b1;
      startJob(ROP_DSTINVERT, 100);
      idx = 0;
      pumpBeats(2000, 100, 1'b1, idx);
      checkOutput("t6_accepts", idx, 100);
      waitIdle(1000);
      checkOutput("t6_done", done_cnt - d0, 1);

      // 7: random modes and lengths against the reference raster op
      $display("[TB] random mode jobs");
      for (int j = 0; j < 6; j++) begin
         logic [7:0] m;
         int len;
         m = 8'($urandom);
         len = $urandom_range(1, 12);
         clearBeats();
         for (int i = 0; i < len; i++) begin
            bp.push_back(4'($urandom)); bs.push_back(4'($urandom)); bd.push_back(4'($urandom));
            exp_q.push_back({(i == len - 1), ropModel(m, bp[i], bs[i], bd[i])});
         end
         d0 = done_cnt;
         startJob(m, len);
         idx = 0;
         pumpBeats(500, len, 1'b1, idx);
         checkOutput("t7_accepts", idx, len);
         waitIdle(500);
         checkOutput("t7_done", done_cnt - d0, 1);
      end
      rr_random = 1'b0;
      res_ready = 1'b1;

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
